ibex_pext_mac_ctrl: RTL and testbench
=====================================

IBEX_PEXT_MAC_CTRL -- requirements
Module: ibex_pext_mac_ctrl

Interface
REQ-001 SHALL have port: clk_i  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_i  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port: en_i  in  1  start request; sampled only in IDLE.
REQ-004 SHALL have port: operator_i  in  pext_mac_op_e  op select: PMUL8, PMUL16 or PMAC16.
REQ-005 SHALL have port: signed_i  in  1  lanes signed (1) or unsigned (0).
REQ-006 SHALL have ports: op_a_i, op_b_i, rd_val_i  in  32 each  source operands and accumulator seed.
REQ-007 SHALL have port: kill_i  in  1  abort current op (flush/exception).
REQ-008 SHALL have port: ready_id_i  in  1  ID stage accepts result.
REQ-009 SHALL have ports: mul_a_o, mul_b_o  out  17 each  operands to the shared 17x17 signed multiplier.
REQ-010 SHALL have port: mul_res_i  in  34  combinational product of mul_a_o*mul_b_o.
REQ-011 SHALL have ports: valid_o (1), busy_o (1), result_o (32), ov_o (1)  out  result-valid, FSM not IDLE, packed result, saturation flag.

Function
REQ-012 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE; busy_o = (state != IDLE).
REQ-013 SHALL, on en_i in IDLE, latch op_a_i, op_b_i, rd_val_i, operator_i and signed_i, clear the lane counter and enter CALC next cycle; input changes after that cycle SHALL have no effect.
REQ-014 SHALL process one lane per CALC cycle; lane count L = 4 for PMUL8 and 2 for PMUL16/PMAC16; lane k occupies CALC cycle k.
REQ-015 SHALL drive mul_a_o/mul_b_o with lane k of the latched operands: 8-bit lanes are bits [8k+7:8k] and 16-bit lanes are bits [16k+15:16k], extended to 17 bits by sign when signed_i=1 and by zero otherwise; outside CALC both SHALL be 0.
REQ-016 SHALL, for PMUL8/PMUL16, write mul_res_i low 8/16 bits into result lane k at end of cycle k.
REQ-017 SHALL, for PMAC16, seed a 34-bit accumulator with rd_val_i on start (sign-extended if signed_i, else zero-extended) and add the sign-extended mul_res_i each CALC cycle.
REQ-018 SHALL, for PMAC16 on entering DONE, saturate the accumulator to [-2^31, 2^31-1] when signed, or to [0, 2^32-1] when unsigned; ov_o=1 iff saturation occurred, else ov_o=0.
REQ-019 SHALL enter DONE after the lane-(L-1) cycle, so valid_o rises exactly L+1 cycles after the en_i cycle (PMUL8: 5, others: 3).
REQ-020 SHALL hold valid_o, result_o and ov_o stable in DONE while ready_id_i=0, and return to IDLE on the cycle after ready_id_i=1.
REQ-021 SHALL assert valid_o only in DONE; result_o and ov_o SHALL be 0 outside DONE.
REQ-022 SHALL, on kill_i=1 in any state, go to IDLE next cycle, with valid_o never asserted for the killed op; kill_i SHALL take priority over ready_id_i and en_i.
REQ-023 SHALL ignore en_i while busy; a new en_i in the IDLE cycle after DONE SHALL be accepted.

Reset
REQ-024 SHALL, when rst_i=1 at a clock edge, set state=IDLE, lane counter=0, and clear the accumulator, latched operands, result register and ov flag, aborting any in-flight op.
REQ-025 SHALL have every output 0 during and immediately after reset.

Structure
REQ-026 SHALL place pext_mac_op_e and the lane-count constants in ibex_pkg; the FSM state enum SHALL stay local.
REQ-027 SHALL contain no sub-module; the multiplier is external and shared, with ibex_ex_block muxing its operands by busy_o.

Verification
REQ-028 PMUL8 unsigned, a=0x04030201, b=0x10101010 -> valid_o at cycle +5, result_o=0x40302010, ov_o=0.
REQ-029 PMUL16 signed, a=0xFFFF0003, b=0x00020005 -> valid_o at cycle +3, result_o=0xFFFE000F.
REQ-030 PMAC16 signed, rd=0x7FFFFFF0, a=0x00010001, b=0x00100010 -> result_o=0x7FFFFFFF, ov_o=1; with rd=0x00000000 -> result_o=0x00000020, ov_o=0.
REQ-031 PMUL8 started, kill_i at cycle +2 -> busy_o=0 at +3, valid_o never 1; en_i at +3 accepted.
REQ-032 PMUL16 completes with ready_id_i=0 for 3 cycles -> valid_o/result_o held 3 cycles, IDLE the cycle after ready_id_i=1.
REQ-033 rst_i=1 during CALC lane 2 -> all outputs 0 the next cycle, FSM IDLE, no stale result on the next op.

Source files
------------

// File: rtl/ibex_pkg.sv
// Shared definitions for the packed-SIMD multiply/accumulate controller.
//   pext_mac_op_e   : operation select (PMUL8, PMUL16, PMAC16)
//   PEXT_LANES_8/16 : number of lanes processed per operation width
//   pext_last_lane  : index of the final lane for a given operation
package ibex_pkg;

  typedef enum logic [1:0] {
    PMUL8  = 2'd0,
    PMUL16 = 2'd1,
    PMAC16 = 2'd2
  } pext_mac_op_e;

  localparam int unsigned PEXT_LANES_8  = 4;
  localparam int unsigned PEXT_LANES_16 = 2;

  function automatic logic [1:0] pext_last_lane(pext_mac_op_e op);
    return (op == PMUL8) ? 2'(PEXT_LANES_8 - 1) : 2'(PEXT_LANES_16 - 1);
  endfunction

endpackage

// File: rtl/ibex_pext_mac_ctrl_if.sv
// Request/response bundle between the ID stage and the P-extension MAC
// controller.
//   en_i / operator_i / signed_i        : start request and op description
//   op_a_i / op_b_i / rd_val_i          : operands and accumulator seed
//   kill_i                              : abort (flush/exception)
//   ready_id_i                          : ID stage accepts the result
//   valid_o / busy_o / result_o / ov_o  : result handshake and status
// master = ID-stage side, slave = controller side.
interface ibex_pext_mac_ctrl_if;
  import ibex_pkg::*;

  logic         en_i;
  pext_mac_op_e operator_i;
  logic         signed_i;
  logic [31:0]  op_a_i;
  logic [31:0]  op_b_i;
  logic [31:0]  rd_val_i;
  logic         kill_i;
  logic         ready_id_i;
  logic         valid_o;
  logic         busy_o;
  logic [31:0]  result_o;
  logic         ov_o;

  modport master (
    output en_i, operator_i, signed_i, op_a_i, op_b_i, rd_val_i, kill_i, ready_id_i,
    input  valid_o, busy_o, result_o, ov_o
  );

  modport slave (
    input  en_i, operator_i, signed_i, op_a_i, op_b_i, rd_val_i, kill_i, ready_id_i,
    output valid_o, busy_o, result_o, ov_o
  );

endinterface

// File: rtl/ibex_pext_mac_ctrl.sv
// Sequencer for packed 8/16-bit multiplies and 16-bit multiply-accumulate
// on a shared external 17x17 signed multiplier, one lane per cycle.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   bus (slave)   : start request, operands, kill, result handshake
//   mul_a_o/b_o   : 17-bit lane operands to the shared multiplier
//   mul_res_i     : 34-bit combinational product from the multiplier
//
// state  | meaning
// -------+--------------------------------------------------------
// IDLE   | waiting for en_i; operands latched on the accepting cycle
// CALC   | one lane per cycle, lane_q selects the active lane
// DONE   | result valid, held until ready_id_i
module ibex_pext_mac_ctrl
  import ibex_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  ibex_pext_mac_ctrl_if.slave  bus,
  output logic [16:0]          mul_a_o,
  output logic [16:0]          mul_b_o,
  input  logic [33:0]          mul_res_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [1:0]   lane_q, lane_d;
  logic [31:0]  op_a_q, op_a_d;
  logic [31:0]  op_b_q, op_b_d;
  pext_mac_op_e operator_q, operator_d;
  logic         signed_q, signed_d;
  logic [33:0]  acc_q, acc_d;
  logic [31:0]  res_q, res_d;
  logic         ov_q, ov_d;

  logic [4:0]   sh_amt;
  logic [15:0]  a_sh, b_sh;
  logic [16:0]  lane_a, lane_b;
  logic [33:0]  acc_sum;
  logic [31:0]  sat_res;
  logic         sat_ov;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      lane_q     <= 2'd0;
      op_a_q     <= 32'd0;
      op_b_q     <= 32'd0;
      operator_q <= PMUL8;
      signed_q   <= 1'b0;
      acc_q      <= 34'd0;
      res_q      <= 32'd0;
      ov_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      operator_q <= operator_d;
      signed_q   <= signed_d;
      acc_q      <= acc_d;
      res_q      <= res_d;
      ov_q       <= ov_d;
    end
  end

  // Lane select: shift the active lane down to bit 0, then extend to 17 bits.
  always_comb begin
    sh_amt = (operator_q == PMUL8) ? {lane_q, 3'b000} : {lane_q[0], 4'b0000};
    a_sh   = 16'(op_a_q >> sh_amt);
    b_sh   = 16'(op_b_q >> sh_amt);
    if (operator_q == PMUL8) begin
      lane_a = {{9{signed_q & a_sh[7]}}, a_sh[7:0]};
      lane_b = {{9{signed_q & b_sh[7]}}, b_sh[7:0]};
    end else begin
      lane_a = {signed_q & a_sh[15], a_sh};
      lane_b = {signed_q & b_sh[15], b_sh};
    end
  end

  // The 34-bit product is already sign-extended, so accumulate directly.
  // Saturation is judged on the sum that includes the final lane.
  always_comb begin
    acc_sum = acc_q + mul_res_i;
    sat_res = acc_sum[31:0];
    sat_ov  = 1'b0;
    if (signed_q) begin
      if (acc_sum[33:31] != 3'b000 && acc_sum[33:31] != 3'b111) begin
        sat_res = acc_sum[33] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        sat_ov  = 1'b1;
      end
    end else if (acc_sum[33:32] != 2'b00) begin
      sat_res = 32'hFFFF_FFFF;
      sat_ov  = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    operator_d = operator_q;
    signed_d   = signed_q;
    acc_d      = acc_q;
    res_d      = res_q;
    ov_d       = ov_q;
    mul_a_o    = 17'd0;
    mul_b_o    = 17'd0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.en_i) begin
          op_a_d     = bus.op_a_i;
          op_b_d     = bus.op_b_i;
          operator_d = bus.operator_i;
          signed_d   = bus.signed_i;
          acc_d      = {{2{bus.signed_i & bus.rd_val_i[31]}}, bus.rd_val_i};
          res_d      = 32'd0;
          ov_d       = 1'b0;
          lane_d     = 2'd0;
          state_d    = S_CALC;
        end
      end
      S_CALC: begin
        mul_a_o = lane_a;
        mul_b_o = lane_b;
        if (operator_q == PMAC16) begin
          acc_d = acc_sum;
        end else if (operator_q == PMUL8) begin
          res_d[{lane_q, 3'b000} +: 8] = mul_res_i[7:0];
        end else begin
          res_d[{lane_q[0], 4'b0000} +: 16] = mul_res_i[15:0];
        end
        if (lane_q == pext_last_lane(operator_q)) begin
          state_d = S_DONE;
          if (operator_q == PMAC16) begin
            res_d = sat_res;
            ov_d  = sat_ov;
          end
        end else begin
          lane_d = lane_q + 2'd1;
        end
      end
      S_DONE: begin
        if (bus.ready_id_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.kill_i) begin
      state_d = S_IDLE;
    end
  end

  assign bus.busy_o   = (state_q != S_IDLE);
  assign bus.valid_o  = (state_q == S_DONE);
  assign bus.result_o = (state_q == S_DONE) ? res_q : 32'd0;
  assign bus.ov_o     = (state_q == S_DONE) ? ov_q : 1'b0;

endmodule

// File: tb/tb_ibex_pext_mac_ctrl.sv
// Self-checking bench for ibex_pext_mac_ctrl: directed cases with literal
// expectations plus randomized traffic compared every cycle against a
// transaction-level model.
module tb_ibex_pext_mac_ctrl;
  import ibex_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] mul_a, mul_b;
  logic [33:0] mul_res;
  logic [33:0] ma_ext, mb_ext;
  bit          cmp_en = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  ibex_pext_mac_ctrl_if bus ();

  ibex_pext_mac_ctrl dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (bus),
    .mul_a_o   (mul_a),
    .mul_b_o   (mul_b),
    .mul_res_i (mul_res)
  );

  always #5 clk = ~clk;

  // Shared 17x17 signed multiplier
  assign ma_ext  = {{17{mul_a[16]}}, mul_a};
  assign mb_ext  = {{17{mul_b[16]}}, mul_b};
  assign mul_res = ma_ext * mb_ext;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic longint lane_val(input logic [31:0] v, input int w, input int k, input bit s);
    longint x;
    x = longint'((v >> (w * k)) & ((32'd1 << w) - 32'd1));
    if (s && x >= (longint'(1) << (w - 1))) x -= (longint'(1) << w);
    return x;
  endfunction

  function automatic void golden(input pext_mac_op_e op, input bit s,
                                 input logic [31:0] a, input logic [31:0] b, input logic [31:0] rd,
                                 output logic [31:0] res, output bit ov);
    longint acc, p;
    int w;
    res = 32'd0;
    ov  = 1'b0;
    if (op == PMAC16) begin
      acc = s ? longint'($signed(rd)) : longint'(rd);
      for (int k = 0; k < 2; k++) acc += lane_val(a, 16, k, s) * lane_val(b, 16, k, s);
      if (s && acc > 64'sd2147483647) begin
        res = 32'h7FFF_FFFF; ov = 1'b1;
      end else if (s && acc < -64'sd2147483648) begin
        res = 32'h8000_0000; ov = 1'b1;
      end else if (!s && acc > 64'sd4294967295) begin
        res = 32'hFFFF_FFFF; ov = 1'b1;
      end else begin
        res = 32'(acc);
      end
    end else begin
      w = (op == PMUL8) ? 8 : 16;
      for (int k = 0; k < 32 / w; k++) begin
        p = lane_val(a, w, k, s) * lane_val(b, w, k, s);
        res |= (32'(p) & ((32'd1 << w) - 32'd1)) << (w * k);
      end
    end
  endfunction

  // Transaction timeline: accepted op spends L cycles in lanes, then waits.
  bit           m_idle = 1'b1;
  bit           m_done = 1'b0;
  int           m_k = 0;
  int           m_L = 0;
  pext_mac_op_e m_op = PMUL8;
  bit           m_sgn = 1'b0;
  logic [31:0]  m_a = '0, m_b = '0, m_res = '0;
  bit           m_ov = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_idle = 1'b1; m_done = 1'b0;
    end else if (bus.kill_i) begin
      m_idle = 1'b1; m_done = 1'b0;
    end else if (m_idle) begin
      if (bus.en_i) begin
        m_op  = bus.operator_i;
        m_sgn = bus.signed_i;
        m_a   = bus.op_a_i;
        m_b   = bus.op_b_i;
        golden(bus.operator_i, bus.signed_i, bus.op_a_i, bus.op_b_i, bus.rd_val_i, m_res, m_ov);
        m_L    = (bus.operator_i == PMUL8) ? 4 : 2;
        m_k    = 0;
        m_idle = 1'b0;
        m_done = 1'b0;
      end
    end else if (!m_done) begin
      if (m_k == m_L - 1) m_done = 1'b1;
      else m_k++;
    end else if (bus.ready_id_i) begin
      m_idle = 1'b1; m_done = 1'b0;
    end
  end

  always @(negedge clk) begin : compare
    logic [16:0] ea, eb;
    bit calc;
    int w;
    if (cmp_en) begin
      calc = !m_idle && !m_done;
      w    = (m_op == PMUL8) ? 8 : 16;
      ea   = calc ? 17'(lane_val(m_a, w, m_k, m_sgn)) : 17'd0;
      eb   = calc ? 17'(lane_val(m_b, w, m_k, m_sgn)) : 17'd0;
      chk("busy",   bus.busy_o,   !m_idle);
      chk("valid",  bus.valid_o,  m_done);
      chk("result", bus.result_o, m_done ? m_res : 32'd0);
      chk("ov",     bus.ov_o,     m_done ? m_ov : 1'b0);
      chk("mul_a",  mul_a, ea);
      chk("mul_b",  mul_b, eb);
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] pick_word();
    case ($urandom_range(0, 7))
      0: return 32'h7FFF_7FFF;
      1: return 32'h8000_8000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFF0;
      default: return $urandom;
    endcase
  endfunction

  task automatic scramble();
    bus.operator_i = pext_mac_op_e'($urandom_range(0, 2));
    bus.signed_i   = 1'($urandom_range(0, 1));
    bus.op_a_i     = $urandom;
    bus.op_b_i     = $urandom;
    bus.rd_val_i   = $urandom;
  endtask

  task automatic run_op(input pext_mac_op_e op, input bit s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] rd, input int exp_lat,
                        input logic [31:0] exp_res, input bit exp_ov, input int hold,
                        input string tag);
    int lat;
    bus.ready_id_i = (hold == 0);
    bus.operator_i = op;
    bus.signed_i   = s;
    bus.op_a_i     = a;
    bus.op_b_i     = b;
    bus.rd_val_i   = rd;
    bus.en_i       = 1'b1;
    tick();
    bus.en_i = 1'b0;
    scramble();
    lat = 1;
    while (!bus.valid_o && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_result"}, bus.result_o, exp_res);
    chk({tag, "_ov"}, bus.ov_o, exp_ov);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({tag, "_hold_valid"}, bus.valid_o, 1'b1);
      chk({tag, "_hold_result"}, bus.result_o, exp_res);
    end
    bus.ready_id_i = 1'b1;
    tick();
    chk({tag, "_idle_after"}, bus.busy_o, 1'b0);
  endtask

  initial begin : main
    logic [31:0] r;
    bit o;

    rst            = 1'b1;
    bus.en_i       = 1'b0;
    bus.kill_i     = 1'b0;
    bus.ready_id_i = 1'b1;
    bus.operator_i = PMUL8;
    bus.signed_i   = 1'b0;
    bus.op_a_i     = 32'd0;
    bus.op_b_i     = 32'd0;
    bus.rd_val_i   = 32'd0;

    // Pin the model against hand-computed values
    golden(PMUL8, 1'b0, 32'h0403_0201, 32'h1010_1010, 32'd0, r, o);
    chk("model_pmul8", {r, 31'd0, o}, {32'h4030_2010, 31'd0, 1'b0});
    golden(PMUL16, 1'b1, 32'hFFFF_0003, 32'h0002_0005, 32'd0, r, o);
    chk("model_pmul16", r, 32'hFFFE_000F);
    golden(PMAC16, 1'b1, 32'h0001_0001, 32'h0010_0010, 32'h7FFF_FFF0, r, o);
    chk("model_pmac_sat", {r, 31'd0, o}, {32'h7FFF_FFFF, 31'd0, 1'b1});
    golden(PMAC16, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, o);
    chk("model_pmac_usat", {r, 31'd0, o}, {32'hFFFF_FFFF, 31'd0, 1'b1});

    tick();
    cmp_en = 1'b1;
    chk("reset_busy",   bus.busy_o,   1'b0);
    chk("reset_valid",  bus.valid_o,  1'b0);
    chk("reset_result", bus.result_o, 32'd0);
    chk("reset_mul_a",  mul_a, 17'd0);
    tick();
    rst = 1'b0;
    tick();

    run_op(PMUL8,  1'b0, 32'h0403_0201, 32'h1010_1010, 32'd0, 5, 32'h4030_2010, 1'b0, 0, "pmul8_u");
    run_op(PMUL16, 1'b1, 32'hFFFF_0003, 32'h0002_0005, 32'd0, 3, 32'hFFFE_000F, 1'b0, 0, "pmul16_s");
    run_op(PMAC16, 1'b1, 32'h0001_0001, 32'h0010_0010, 32'h7FFF_FFF0, 3, 32'h7FFF_FFFF, 1'b1, 0, "pmac_sat");
    run_op(PMAC16, 1'b1, 32'h0001_0001, 32'h0010_0010, 32'h0000_0000, 3, 32'h0000_0020, 1'b0, 0, "pmac_nosat");
    run_op(PMAC16, 1'b1, 32'h8000_8000, 32'h7FFF_7FFF, 32'h8000_0000, 3, 32'h8000_0000, 1'b1, 0, "pmac_negsat");
    run_op(PMUL16, 1'b0, 32'h1234_0010, 32'h0002_0003, 32'd0, 3, 32'h2468_0030, 1'b0, 3, "pmul16_hold");

    // Kill mid-flight, then restart in the following cycle
    bus.operator_i = PMUL8;
    bus.signed_i   = 1'b0;
    bus.op_a_i     = 32'h0101_0101;
    bus.op_b_i     = 32'h0202_0202;
    bus.en_i       = 1'b1;
    tick();
    bus.en_i = 1'b0;
    tick();
    bus.kill_i = 1'b1;
    tick();
    bus.kill_i = 1'b0;
    chk("kill_busy",  bus.busy_o,  1'b0);
    chk("kill_valid", bus.valid_o, 1'b0);
    run_op(PMUL16, 1'b1, 32'h0002_FFFF, 32'h0003_0004, 32'd0, 3, 32'h0006_FFFC, 1'b0, 0, "after_kill");

    // Reset during lane 2 of PMUL8
    bus.operator_i = PMUL8;
    bus.signed_i   = 1'b0;
    bus.op_a_i     = 32'h0403_0201;
    bus.op_b_i     = 32'h1010_1010;
    bus.en_i       = 1'b1;
    tick();
    bus.en_i = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_busy",   bus.busy_o,   1'b0);
    chk("rst_valid",  bus.valid_o,  1'b0);
    chk("rst_result", bus.result_o, 32'd0);
    chk("rst_ov",     bus.ov_o,     1'b0);
    chk("rst_mul_b",  mul_b, 17'd0);
    run_op(PMUL16, 1'b0, 32'h0003_0002, 32'h0005_0004, 32'd0, 3, 32'h000F_0008, 1'b0, 0, "after_rst");

    // Randomized traffic checked by the compare process
    for (int i = 0; i < 600; i++) begin
      bus.en_i       = ($urandom_range(0, 2) == 0);
      bus.operator_i = pext_mac_op_e'($urandom_range(0, 2));
      bus.signed_i   = 1'($urandom_range(0, 1));
      bus.op_a_i     = pick_word();
      bus.op_b_i     = pick_word();
      bus.rd_val_i   = pick_word();
      bus.kill_i     = ($urandom_range(0, 24) == 0);
      bus.ready_id_i = ($urandom_range(0, 3) != 0);
      rst            = ($urandom_range(0, 149) == 0);
      tick();
    end
    bus.en_i   = 1'b0;
    bus.kill_i = 1'b0;
    rst        = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
